systolic_seq_ctrl: RTL

//  Sequencer for the NxN output-stationary systolic array behind tt_um_haoyang_systolicarray.

---
 rtl/systolic_seq_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_seq_ctrl
// Purpose  : Operand loader, skewed feed sequencer and byte-serial result
//            reader for an NxN output-stationary systolic array.
// Revision : 1.0  initial release
// ============================================================================
module systolic_seq_ctrl #(
    parameter int N     = 2,
    parameter int DW    = 8,
    parameter int ACCW  = 16,
    parameter int DRAIN = 4,
    localparam int SELW = (N * N > 1) ? $clog2(N * N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_abort,
    input  logic              i_in_valid,
    input  logic [DW-1:0]     i_in_data,
    output logic              o_in_ready,
    output logic              o_acc_clr,
    output logic [N*DW-1:0]   o_a_feed,
    output logic [N-1:0]      o_a_vld,
    output logic [N*DW-1:0]   o_b_feed,
    output logic [N-1:0]      o_b_vld,
    output logic [SELW-1:0]   o_res_sel,
    input  logic [ACCW-1:0]   i_res_data,
    output logic              o_out_valid,
    output logic [7:0]        o_out_data,
    input  logic              i_out_ready,
    output logic              o_busy
);

    localparam int c_NB    = ACCW / 8;
    localparam int c_NBUF  = N * N;
    localparam int c_NLOAD = 2 * N * N;
    localparam int c_NFEED = 2 * N - 1;
    localparam int c_NOUT  = N * N * c_NB;
    localparam int c_M1    = (c_NLOAD > c_NOUT) ? c_NLOAD : c_NOUT;
    localparam int c_M2    = (c_M1 > DRAIN) ? c_M1 : DRAIN;
    localparam int c_MAXC  = (c_M2 > c_NFEED) ? c_M2 : c_NFEED;
    localparam int c_CW    = $clog2(c_MAXC + 1);
    localparam int c_IW    = (c_NBUF > 1) ? $clog2(c_NBUF) : 1;

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_CW-1:0]     r_cnt, w_cnt_nxt;
    logic [DW-1:0]       r_abuf [c_NBUF];
    logic [DW-1:0]       r_bbuf [c_NBUF];
    logic [N*DW-1:0]     r_a_feed, r_b_feed, w_a_feed_nxt, w_b_feed_nxt;
    logic [N-1:0]        r_a_vld, r_b_vld, w_a_vld_nxt, w_b_vld_nxt;
    logic                w_in_fire, w_out_fire, w_feed_go;
    logic [c_CW-1:0]     w_tn, w_sel_full, w_bsel;
    logic [7:0]          w_byte;

    assign o_in_ready  = (r_state == S_LOAD);
    assign o_out_valid = (r_state == S_OUT);
    assign o_acc_clr   = (r_state == S_CLEAR);
    assign o_busy      = !((r_state == S_LOAD) && (r_cnt == '0));
    // abort wins over both handshakes in the same cycle
    assign w_in_fire   = i_in_valid && o_in_ready && !i_abort;
    assign w_out_fire  = o_out_valid && i_out_ready && !i_abort;

    assign w_sel_full  = r_cnt / c_CW'(c_NB);
    assign w_bsel      = r_cnt % c_CW'(c_NB);
    assign o_res_sel   = o_out_valid ? SELW'(w_sel_full) : '0;
    assign o_out_data  = o_out_valid ? w_byte : 8'h00;

    assign o_a_feed    = r_a_feed;
    assign o_a_vld     = r_a_vld;
    assign o_b_feed    = r_b_feed;
    assign o_b_vld     = r_b_vld;

    always_comb begin
        w_byte = 8'h00;
        for (int b = 0; b < c_NB; b++) begin
            if (w_bsel == c_CW'(b)) w_byte = i_res_data[b*8 +: 8];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_abort) begin
            w_state_nxt = S_LOAD;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_in_fire) begin
                        if (r_cnt == c_CW'(c_NLOAD - 1)) begin
                            w_state_nxt = S_CLEAR;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    w_state_nxt = S_FEED;
                    w_cnt_nxt   = '0;
                end
                S_FEED: begin
                    if (r_cnt == c_CW'(c_NFEED - 1)) begin
                        w_state_nxt = S_DRAIN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == c_CW'(DRAIN - 1)) begin
                        w_state_nxt = S_OUT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    if (w_out_fire) begin
                        if (r_cnt == c_CW'(c_NOUT - 1)) begin
                            w_state_nxt = S_LOAD;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_LOAD;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Feed registers are loaded one cycle ahead: CLEAR prepares t=0, FEED t prepares t+1.
    always_comb begin
        w_a_feed_nxt = '0;
        w_b_feed_nxt = '0;
        w_a_vld_nxt  = '0;
        w_b_vld_nxt  = '0;
        w_feed_go    = 1'b0;
        w_tn         = '0;
        if (!i_abort) begin
            if (r_state == S_CLEAR) begin
                w_feed_go = 1'b1;
            end else if ((r_state == S_FEED) && (r_cnt != c_CW'(c_NFEED - 1))) begin
                w_feed_go = 1'b1;
                w_tn      = r_cnt + 1'b1;
            end
        end
        if (w_feed_go) begin
            for (int i = 0; i < N; i++) begin
                if ((int'(w_tn) >= i) && (int'(w_tn) - i < N)) begin
                    w_a_vld_nxt[i]           = 1'b1;
                    w_a_feed_nxt[i*DW +: DW] = r_abuf[c_IW'(i * N + int'(w_tn) - i)];
                    w_b_vld_nxt[i]           = 1'b1;
                    w_b_feed_nxt[i*DW +: DW] = r_bbuf[c_IW'((int'(w_tn) - i) * N + i)];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_LOAD;
            r_cnt    <= '0;
            r_a_feed <= '0;
            r_b_feed <= '0;
            r_a_vld  <= '0;
            r_b_vld  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_a_feed <= w_a_feed_nxt;
            r_b_feed <= w_b_feed_nxt;
            r_a_vld  <= w_a_vld_nxt;
            r_b_vld  <= w_b_vld_nxt;
        end
    end

    // Operand buffer keeps its contents across reset; only the counter restarts.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            if (r_cnt < c_CW'(c_NBUF)) begin
                r_abuf[c_IW'(r_cnt)] <= i_in_data;
            end else begin
                r_bbuf[c_IW'(r_cnt - c_CW'(c_NBUF))] <= i_in_data;
            end
        end
    end

endmodule
`default_nettype wire
